// File: rtl/rle_stream_encoder.sv
// Run-length encoder: pixel stream in, (value, run-length) pairs out, both valid/ready.
// Define RLE_TOLERANCE_EN for near-lossless matching within TOLERANCE.
module rle_stream_encoder #(
   parameter int unsigned PIXEL_W   = 8,
   parameter int unsigned COUNT_W   = 8,
   parameter int unsigned STAT_W    = 16,
   parameter int unsigned TOLERANCE = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [PIXEL_W-1:0] pixel_in,
   input  logic               valid_in,
   input  logic               last_in,
   output logic               in_ready,
   output logic [PIXEL_W-1:0] data_out,
   output logic [COUNT_W-1:0] count_out,
   output logic               valid_out,
   input  logic               out_ready,
   output logic               last_out,
   output logic               busy,
   output logic               done,
   output logic [STAT_W-1:0]  original_count,
   output logic [STAT_W-1:0]  compressed_count
);

   localparam int unsigned DIFF_W = PIXEL_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [PIXEL_W-1:0] cur;
   logic [COUNT_W-1:0] run;
   logic               have_run;
   logic               final_loaded;
   logic               match;
   logic               accept;
   logic               extend;
   logic               load_pair;
   logic               load_final;
   logic               consume;

`ifdef RLE_TOLERANCE_EN
   logic [DIFF_W-1:0] diff;
   assign diff  = (pixel_in >= cur) ? DIFF_W'(pixel_in) - DIFF_W'(cur)
                                    : DIFF_W'(cur) - DIFF_W'(pixel_in);
   assign match = (diff <= DIFF_W'(TOLERANCE));
`else
   logic [DIFF_W-1:0] unused_tolerance;
   assign unused_tolerance = DIFF_W'(TOLERANCE);
   assign match = (pixel_in == cur);
`endif

   // Single output slot: accept a pixel only if any pair it produces has room.
   assign in_ready = (state == S_RUN) && (!valid_out || out_ready);
   assign consume  = valid_out && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      extend     = 1'b0;
      load_pair  = 1'b0;
      load_final = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            accept = valid_in && in_ready;
            if (accept) begin
               if (have_run && match && (run != '1)) extend = 1'b1;
               else if (have_run)                    load_pair = 1'b1;
               if (last_in) state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (!final_loaded && (!valid_out || out_ready)) load_final = 1'b1;
            else if (final_loaded && consume)               state_nxt  = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Run tracking, output slot and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur              <= '0;
         run              <= '0;
         have_run         <= 1'b0;
         final_loaded     <= 1'b0;
         data_out         <= '0;
         count_out        <= '0;
         valid_out        <= 1'b0;
         last_out         <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         original_count   <= '0;
         compressed_count <= '0;
      end else begin
         busy <= (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
         done <= (state_nxt == S_DONE);

         if ((state == S_IDLE) && start) begin
            run              <= '0;
            have_run         <= 1'b0;
            final_loaded     <= 1'b0;
            original_count   <= '0;
            compressed_count <= '0;
         end

         if (consume) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
         end

         if (accept) begin
            if (original_count != '1) original_count <= original_count + STAT_W'(1);
            if (extend) begin
               run <= run + COUNT_W'(1);
            end else begin
               cur      <= pixel_in;
               run      <= COUNT_W'(1);
               have_run <= 1'b1;
            end
         end

         if (load_pair || load_final) begin
            data_out  <= cur;
            count_out <= run;
            valid_out <= 1'b1;
            last_out  <= load_final;
            if (compressed_count != '1) compressed_count <= compressed_count + STAT_W'(1);
         end

         if (load_final) final_loaded <= 1'b1;
      end
   end

endmodule
